// File: rtl/dice_roll_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dice_roll_controller: die-select arbitration, spin/settle/show sequencing,   |
// | 1..N result register and BCD display digits.  Rev 1.0                        |
// +-----------------------------------------------------------------------------+
module dice_roll_controller #(
  parameter int SETTLE_STEPS  = 6,
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [6:0] btn,
  output logic [2:0] die_sel,
  output logic [3:0] digit10,
  output logic [3:0] digit1,
  output logic       show,
  output logic       rolling
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SPIN   = 2'd1,
    S_SETTLE = 2'd2,
    S_SHOW   = 2'd3
  } state_t;

  localparam logic [3:0] C_STEPS   = 4'(SETTLE_STEPS);
  localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT_TICKS);

  state_t     r_state, w_state_nxt;
  logic [6:0] r_value, w_value_nxt;
  logic [3:0] r_step, w_step_nxt;
  logic [7:0] r_timeout, w_timeout_nxt;
  logic [2:0] w_die_nxt;
  logic [2:0] w_grant;
  logic       w_any;
  logic [6:0] w_dec;
  logic [6:0] w_mod100;
  logic [3:0] w_tens;
  logic [3:0] w_units;

  function automatic logic [6:0] die_max(input logic [2:0] d);
    case (d)
      3'd0:    die_max = 7'd4;
      3'd1:    die_max = 7'd6;
      3'd2:    die_max = 7'd8;
      3'd3:    die_max = 7'd10;
      3'd4:    die_max = 7'd12;
      3'd5:    die_max = 7'd20;
      3'd6:    die_max = 7'd100;
      default: die_max = 7'd4;
    endcase
  endfunction

  // Fixed priority: the lowest-indexed pressed button wins.
  always_comb begin
    w_grant = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (btn[i]) w_grant = 3'(i);
    end
  end

  assign w_any = |btn;
  assign w_dec = (r_value == 7'd1) ? die_max(die_sel) : r_value - 7'd1;

  always_comb begin
    w_state_nxt   = r_state;
    w_value_nxt   = r_value;
    w_die_nxt     = die_sel;
    w_step_nxt    = r_step;
    w_timeout_nxt = r_timeout;
    case (r_state)
      S_IDLE, S_SHOW: begin
        if (w_any) begin
          w_die_nxt   = w_grant;
          w_value_nxt = die_max(w_grant);
          w_state_nxt = S_SPIN;
        end else if (r_state == S_SHOW && tick) begin
          w_timeout_nxt = r_timeout - 8'd1;
          if (r_timeout == 8'd1) w_state_nxt = S_IDLE;
        end
      end
      S_SPIN: begin
        if (btn[die_sel]) begin
          w_value_nxt = w_dec;
        end else begin
          w_step_nxt  = 4'd0;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (tick) begin
          w_value_nxt = w_dec;
          w_step_nxt  = r_step + 4'd1;
          if (r_step + 4'd1 == C_STEPS) begin
            w_timeout_nxt = C_TIMEOUT;
            w_state_nxt   = S_SHOW;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Digits are taken from the next value so they register alongside it; 100 shows as 00.
  always_comb begin
    w_mod100 = (w_value_nxt >= 7'd100) ? w_value_nxt - 7'd100 : w_value_nxt;
    w_tens   = 4'd0;
    for (int i = 1; i <= 9; i++) begin
      if (w_mod100 >= 7'(10 * i)) w_tens = 4'(i);
    end
    w_units = w_mod100[3:0] - (w_tens * 4'd10);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_value   <= 7'd1;
      r_step    <= 4'd0;
      r_timeout <= 8'd0;
      die_sel   <= 3'd0;
      digit10   <= 4'd0;
      digit1    <= 4'd1;
      show      <= 1'b0;
      rolling   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_value   <= w_value_nxt;
      r_step    <= w_step_nxt;
      r_timeout <= w_timeout_nxt;
      die_sel   <= w_die_nxt;
      digit10   <= w_tens;
      digit1    <= w_units;
      show      <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_SHOW);
      rolling   <= (w_state_nxt == S_SPIN) || (w_state_nxt == S_SETTLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dice_roll_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_dice_roll_controller: directed and randomized bench with a reference     |
// | model of the roll sequence.  Rev 1.0                                         |
// +-----------------------------------------------------------------------------+
module tb_dice_roll_controller;

  localparam int SETTLE_STEPS  = 6;
  localparam int TIMEOUT_TICKS = 3;

  localparam int P_IDLE   = 0;
  localparam int P_SPIN   = 1;
  localparam int P_SETTLE = 2;
  localparam int P_SHOW   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [6:0] btn = 7'h00;
  logic [2:0] die_sel;
  logic [3:0] digit10;
  logic [3:0] digit1;
  logic       show;
  logic       rolling;

  int errors = 0;
  int checks = 0;

  int m_phase = P_IDLE;
  int m_value = 1;
  int m_die   = 0;
  int m_steps = 0;
  int m_left  = 0;

  dice_roll_controller #(
    .SETTLE_STEPS (SETTLE_STEPS),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick),
    .btn    (btn),
    .die_sel(die_sel),
    .digit10(digit10),
    .digit1 (digit1),
    .show   (show),
    .rolling(rolling)
  );

  always #5 clk = ~clk;

  function automatic int die_n(input int d);
    case (d)
      0: return 4;
      1: return 6;
      2: return 8;
      3: return 10;
      4: return 12;
      5: return 20;
      default: return 100;
    endcase
  endfunction

  // One step down the die's face ring: 1 wraps to N.
  function automatic int ring_down(input int v, input int n);
    return ((v - 2 + n) % n) + 1;
  endfunction

  task automatic model_edge(input logic r, input logic [6:0] b, input logic t);
    if (!r) begin
      m_phase = P_IDLE; m_value = 1; m_die = 0; m_steps = 0; m_left = 0;
    end else if ((m_phase == P_IDLE || m_phase == P_SHOW) && b != 7'h00) begin
      for (int i = 6; i >= 0; i--) if (b[i]) m_die = i;
      m_value = die_n(m_die);
      m_phase = P_SPIN;
    end else if (m_phase == P_SHOW) begin
      if (t) begin
        if (m_left == 1) m_phase = P_IDLE;
        m_left = m_left - 1;
      end
    end else if (m_phase == P_SPIN) begin
      if (b[m_die]) m_value = ring_down(m_value, die_n(m_die));
      else begin
        m_phase = P_SETTLE;
        m_steps = 0;
      end
    end else if (m_phase == P_SETTLE && t) begin
      m_value = ring_down(m_value, die_n(m_die));
      m_steps = m_steps + 1;
      if (m_steps == SETTLE_STEPS) begin
        m_phase = P_SHOW;
        m_left  = TIMEOUT_TICKS;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [6:0] b, input logic t);
    rst_n = r;
    btn   = b;
    tick  = t;
    @(posedge clk);
    model_edge(r, b, t);
    #1;
    chk("die_sel", 8'(die_sel), 8'(m_die));
    chk("digit10", 8'(digit10), 8'((m_value % 100) / 10));
    chk("digit1",  8'(digit1),  8'(m_value % 10));
    chk("show",    8'(show),    8'(m_phase == P_SETTLE || m_phase == P_SHOW));
    chk("rolling", 8'(rolling), 8'(m_phase == P_SPIN || m_phase == P_SETTLE));
  endtask

  task automatic tick_cycle(input logic [6:0] b);
    step(1'b1, b, 1'b1);
    step(1'b1, b, 1'b0);
  endtask

  int spin_exp[6]   = '{4, 3, 2, 1, 4, 3};
  int settle_exp[6] = '{2, 1, 4, 3, 2, 1};

  initial begin
    logic [6:0] cur;

    // Reset with every button held, then release into a die-0 grant.
    step(1'b0, 7'h7F, 1'b0);
    step(1'b0, 7'h7F, 1'b0);
    chk("rst_die", 8'(die_sel), 8'd0);
    chk("rst_d10", 8'(digit10), 8'd0);
    chk("rst_d1",  8'(digit1),  8'd1);
    chk("rst_show", 8'(show), 8'd0);
    chk("rst_roll", 8'(rolling), 8'd0);
    step(1'b1, 7'h7F, 1'b0);
    chk("grant0_die", 8'(die_sel), 8'd0);
    chk("grant0_roll", 8'(rolling), 8'd1);

    // d4 wrap through spin and settle.
    step(1'b0, 7'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 7'h01, 1'b0);
      chk("d4_spin", 8'(digit1), 8'(spin_exp[i]));
    end
    step(1'b1, 7'h00, 1'b0);
    chk("d4_release_show", 8'(show), 8'd1);
    chk("d4_release_val", 8'(digit1), 8'd3);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 7'h00, 1'b1);
      chk("d4_settle", 8'(digit1), 8'(settle_exp[i]));
      step(1'b1, 7'h00, 1'b0);
    end
    chk("d4_show", 8'(show), 8'd1);
    chk("d4_show_roll", 8'(rolling), 8'd0);

    // Timeout after three ticks, digits retained.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 7'h00, 1'b1);
      chk("timeout_show", 8'(show), (i < 2) ? 8'd1 : 8'd0);
      step(1'b1, 7'h00, 1'b0);
    end
    chk("timeout_digit", 8'(digit1), 8'd1);

    // Priority d10 over d20, then d20 held through settle re-grants in SHOW.
    step(1'b1, 7'h28, 1'b0);
    chk("prio_die", 8'(die_sel), 8'd3);
    chk("prio_d10", 8'(digit10), 8'd1);
    chk("prio_d1", 8'(digit1), 8'd0);
    step(1'b1, 7'h20, 1'b0);
    chk("hand_settle", 8'(show), 8'd1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 7'h20, 1'b1);
      if (i < 5) step(1'b1, 7'h20, 1'b0);
    end
    chk("hand_show_roll", 8'(rolling), 8'd0);
    step(1'b1, 7'h20, 1'b0);
    chk("hand_die", 8'(die_sel), 8'd5);
    chk("hand_d10", 8'(digit10), 8'd2);
    chk("hand_roll", 8'(rolling), 8'd1);

    // Settle d20, then re-grant d100 on the final timeout tick.
    step(1'b1, 7'h00, 1'b0);
    for (int i = 0; i < 6; i++) tick_cycle(7'h00);
    tick_cycle(7'h00);
    tick_cycle(7'h00);
    step(1'b1, 7'h40, 1'b1);
    chk("regrant_die", 8'(die_sel), 8'd6);
    chk("regrant_roll", 8'(rolling), 8'd1);
    chk("d100_d10", 8'(digit10), 8'd0);
    chk("d100_d1", 8'(digit1), 8'd0);
    step(1'b1, 7'h00, 1'b0);
    for (int i = 0; i < 6; i++) tick_cycle(7'h00);
    chk("d100_res10", 8'(digit10), 8'd9);
    chk("d100_res1", 8'(digit1), 8'd4);

    // Reset in the middle of settling.
    step(1'b1, 7'h02, 1'b0);
    step(1'b1, 7'h00, 1'b0);
    tick_cycle(7'h00);
    tick_cycle(7'h00);
    step(1'b0, 7'h00, 1'b0);
    chk("midrst_d1", 8'(digit1), 8'd1);
    chk("midrst_show", 8'(show), 8'd0);
    for (int i = 0; i < 10; i++) tick_cycle(7'h00);
    chk("midrst_noshow", 8'(show), 8'd0);

    // Randomized traffic.
    cur = 7'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0)
        cur = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'($urandom);
      step(($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1, cur,
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
